// File: rtl/psmac_pkg.sv
// Shared types, fixed OAFU 8x8 configuration and operand replication helpers
// for the psmac operand sequencer.
package psmac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // OAFU shift/mode codes selecting signed 8x8 operation
  localparam logic [3:0] SX1   = 4'h0;
  localparam logic [3:0] SX2   = 4'hA;
  localparam logic [3:0] SX3   = 4'h0;
  localparam logic [3:0] SX4   = 4'hA;
  localparam logic [3:0] SY1   = 4'h0;
  localparam logic [3:0] SY2   = 4'h0;
  localparam logic [3:0] SY3   = 4'hC;
  localparam logic [3:0] SY4   = 4'hC;
  localparam logic       MODE1 = 1'b1;
  localparam logic       MODE2 = 1'b1;

  function automatic logic [31:0] pack_a(input logic [7:0] a);
    return {a[7:4], a[7:4], a[3:0], a[3:0], a[7:4], a[7:4], a[3:0], a[3:0]};
  endfunction

  function automatic logic [31:0] pack_b(input logic [7:0] b);
    return {b[7:6], b[7:6], b[5:4], b[5:4], b[7:6], b[7:6], b[5:4], b[5:4],
            b[3:2], b[3:2], b[1:0], b[1:0], b[3:2], b[3:2], b[1:0], b[1:0]};
  endfunction

endpackage

// File: rtl/psmac_vld_pipe.sv
// Valid-bit shift register that tracks products in flight through the OAFU;
// the last stage marks the cycle its product is ready to accumulate.
module psmac_vld_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic push_i,
  output logic last_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;

  generate
    if (LAT == 1) begin : g_single
      always_comb vld_d = push_i;
    end else begin : g_multi
      always_comb vld_d = {vld_q[LAT-2:0], push_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign last_o = vld_q[LAT-1];

endmodule

// File: rtl/psmac_seq.sv
// Operand sequencer and dot-product accumulator in front of one OAFU running
// in signed 8x8 mode: issues operand pairs, retires products, returns the sum.
module psmac_seq
  import psmac_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 9,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy,
  output logic [31:0]      oafu_a,
  output logic [31:0]      oafu_b,
  output logic [3:0]       oafu_sx1,
  output logic [3:0]       oafu_sx2,
  output logic [3:0]       oafu_sx3,
  output logic [3:0]       oafu_sx4,
  output logic [3:0]       oafu_sy1,
  output logic [3:0]       oafu_sy2,
  output logic [3:0]       oafu_sy3,
  output logic [3:0]       oafu_sy4,
  output logic             oafu_mode1,
  output logic             oafu_mode2,
  input  logic [15:0]      oafu_y
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] retired_q, retired_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      oafu_a_q, oafu_a_d;
  logic [31:0]      oafu_b_q, oafu_b_d;

  logic start_acc;
  logic issue;
  logic retire;

  assign start_acc = (state_q == S_IDLE) && start;
  assign in_ready  = (state_q == S_RUN) && (issued_q != len_q);
  assign issue     = in_valid && in_ready;

  psmac_vld_pipe #(
    .LAT (MAC_LAT)
  ) u_vld_pipe (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start_acc),
    .push_i  (issue),
    .last_o  (retire)
  );

  // A new job clears the accumulator and counters; the size cast sign-extends y
  always_comb begin
    len_d     = start_acc ? len : len_q;
    issued_d  = start_acc ? '0 : issued_q + LEN_W'(issue);
    retired_d = start_acc ? '0 : retired_q + LEN_W'(retire);
    acc_d     = acc_q;
    if (start_acc) begin
      acc_d = '0;
    end else if (retire) begin
      acc_d = acc_q + ACC_W'($signed(oafu_y));
    end
    oafu_a_d = issue ? pack_a(in_a) : oafu_a_q;
    oafu_b_d = issue ? pack_b(in_b) : oafu_b_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issued_d == len_q) state_d = S_DRAIN;
      S_DRAIN: if (retired_d == len_q) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      acc_q     <= '0;
      oafu_a_q  <= '0;
      oafu_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      acc_q     <= acc_d;
      oafu_a_q  <= oafu_a_d;
      oafu_b_q  <= oafu_b_d;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_acc    = acc_q;
  assign oafu_a     = oafu_a_q;
  assign oafu_b     = oafu_b_q;
  assign oafu_sx1   = SX1;
  assign oafu_sx2   = SX2;
  assign oafu_sx3   = SX3;
  assign oafu_sx4   = SX4;
  assign oafu_sy1   = SY1;
  assign oafu_sy2   = SY2;
  assign oafu_sy3   = SY3;
  assign oafu_sy4   = SY4;
  assign oafu_mode1 = MODE1;
  assign oafu_mode2 = MODE2;

endmodule
